dcache: RTL
===========

DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter SET_NUM, default 256: number of direct-mapped sets; index = va[11:4].
REQ-002 Parameter LINE_WORDS, default 4: 32-bit words per line (16 B); word select = va[3:2].
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 dcache_idx  in  12  virtual page-offset of request, used for set/word index.
REQ-006 dcache_op  in  5  DC_NOP / DC_R / DC_W.
REQ-007 dcache_pa  in  32  physical address, same cycle as idx; [31:12] is the tag.
REQ-008 dcache_is_cached  in  1  1 = cacheable, 0 = uncached access.
REQ-009 dcache_byte_type  in  byte_type_t  BYTE / HALF / WORD.
REQ-010 wr_dcache_data  in  32  store data, right-aligned, unshifted.
REQ-011 rd_data  out  32  raw aligned load word, valid in the response cycle.
REQ-012 busy  out  1  pipeline stall; 1 = request in progress, inputs ignored.
REQ-013 rd_req / rd_type / rd_addr  out  1/1/32  bus read; rd_type 0 = word, 1 = line.
REQ-014 rd_rdy, ret_valid, ret_last  in  1 each  bus read accept, beat valid, last beat.
REQ-015 ret_data  in  32  bus read beat data.
REQ-016 wr_req / wr_addr / wr_data / wr_strb  out  1/32/32/4  bus single-word write.
REQ-017 wr_rdy  in  1  bus write accept.

Function
REQ-018 Accept: op != DC_NOP sampled in a cycle with busy==0 (cycle N); request registered; tag/valid/data RAM read at idx in N.
REQ-019 FSM states IDLE, LOOKUP, MISS, REFILL, UC_RD, UC_WAIT, WRITE, RESP.
REQ-020 LOOKUP (N+1): hit = valid[set] & tag[set]==pa_r[31:12] & cached_r.
REQ-021 Cached load hit: rd_data = line word, busy=0 in N+1, return to IDLE or accept next request.
REQ-022 Cached load miss: busy=1 from N+1; MISS holds rd_req=1, rd_type=1, rd_addr={pa[31:4],4'b0} until rd_rdy.
REQ-023 REFILL: write beats word 0..LINE_WORDS-1 in order on ret_valid; on ret_last set valid/tag; next cycle RESP.
REQ-024 RESP: busy=0, rd_data = requested word, one cycle.
REQ-025 Uncached load: UC_RD rd_req=1, rd_type=0, rd_addr=pa until rd_rdy; UC_WAIT captures ret_data on ret_valid; cache state untouched; then RESP.
REQ-026 Store, all kinds: write-through, no-write-allocate; WRITE holds wr_req=1 until wr_rdy, busy=1 from N+1 through the handshake cycle; busy=0 the next cycle.
REQ-027 Store cached hit: data RAM word updated with wr_strb in N+1; miss or uncached: no cache update.
REQ-028 wr_addr = {pa[31:2],2'b0}; wr_data = data << 8*pa[1:0].
REQ-029 wr_strb = BYTE 4'b0001<<pa[1:0]; HALF 4'b0011<<{pa[1],1'b0}; WORD 4'b1111.
REQ-030 rd_req and wr_req are never both 1; rd_addr, wr_* stable while req high.
REQ-031 Inputs ignored while busy=1; upstream holds them stable (is_stall).
REQ-032 No flush input; every accepted request completes.
REQ-033 Alignment is unchecked; inputs are exception-free.
REQ-034 Load immediately after store to same word: RESP/hit returns the stored value.
REQ-035 ret_valid outside REFILL/UC_WAIT is ignored.

Reset
REQ-036 On rst_n low: state IDLE, all valid bits 0, busy 0, rd_req 0, wr_req 0, rd_data 0; tags/data don't-care.
REQ-037 Reset mid-REFILL/WRITE abandons the transaction; the line stays invalid.

Structure
REQ-038 Shared package holds byte_type_t, DC_NOP/DC_R/DC_W codes, the dcache state enum and the bus rd_type codes.
REQ-039 Sub-module dcache_data_ram: synchronous-read, per-byte write-enable, SET_NUM x LINE_WORDS x 32.

Verification
REQ-040 Cold load DC_R pa=0x0000_1234 cached -> rd_req line addr 0x0000_1230; after 4 beats RESP rd_data = beat 1.
REQ-041 Repeat load pa=0x0000_1238 -> hit, busy=0 in N+1, rd_data = beat 2, no bus activity.
REQ-042 DC_W BYTE pa=0x0000_1231 data 0xAB (hit) -> wr_strb 0010, wr_data 0x0000_AB00; a following load of 0x1230 returns the byte updated.
REQ-043 Uncached load pa=0x1FE0_0000 -> rd_type 0; result returned; second access misses again.
REQ-044 Alias: pa 0x0000_1234 vs 0x0002_1234 -> second access misses and evicts the first line.
REQ-045 rst_n pulsed during REFILL beat 2 -> busy 0 and rd_req 0 immediately; the next load of the same address misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and codes for the direct-mapped, write-through data cache.
//   byte_type_t     : access size of a load/store
//   DC_NOP/DC_R/DC_W: request opcodes on dcache_op
//   RD_TYPE_*       : bus read size (single word / whole line)
//   dcache_state_e  : controller states
package dcache_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } byte_type_t;

  localparam logic [4:0] DC_NOP = 5'd0;
  localparam logic [4:0] DC_R   = 5'd1;
  localparam logic [4:0] DC_W   = 5'd2;

  localparam logic RD_TYPE_WORD = 1'b0;
  localparam logic RD_TYPE_LINE = 1'b1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS, REFILL, UC_RD, UC_WAIT, WRITE, RESP
  } dcache_state_e;

  // Byte lanes touched by a store of size bt at byte offset off.
  function automatic logic [3:0] byte_strb(input byte_type_t bt, input logic [1:0] off);
    case (bt)
      BYTE:    return 4'b0001 << off;
      HALF:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Data array of the cache: SET_NUM lines x LINE_WORDS words x 32 bits.
//   clk        : clock
//   i_rd_en    : capture word at i_rd_set/i_rd_word; o_rd_data holds otherwise
//   o_rd_data  : synchronous read data (valid the cycle after i_rd_en)
//   i_wr_en    : write i_wr_data into i_wr_set/i_wr_word on lanes in i_wr_strb
module dcache_data_ram #(
  parameter int unsigned SET_NUM    = 256,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned IDX_W     = $clog2(SET_NUM),
  localparam int unsigned WRD_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_set,
  input  logic [WRD_W-1:0] i_rd_word,
  output logic [31:0]      o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_set,
  input  logic [WRD_W-1:0] i_wr_word,
  input  logic [3:0]       i_wr_strb,
  input  logic [31:0]      i_wr_data
);

  logic [3:0][7:0] r_mem [SET_NUM][LINE_WORDS];
  logic [31:0]     r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_strb[b]) r_mem[i_wr_set][i_wr_word][b] <= i_wr_data[8*b +: 8];
      end
    end
    if (i_rd_en) r_rd_data <= r_mem[i_rd_set][i_rd_word];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
//   i_dcache_*         : request (idx = virtual page offset, pa = physical address)
//   o_rd_data / o_busy : load result and pipeline stall
//   o_rd_* / i_rd_rdy / i_ret_* : bus read (word or line refill)
//   o_wr_* / i_wr_rdy  : bus single-word write
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned SET_NUM    = 256,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_dcache_idx,
  input  logic [4:0]  i_dcache_op,
  input  logic [31:0] i_dcache_pa,
  input  logic        i_dcache_is_cached,
  input  byte_type_t  i_dcache_byte_type,
  input  logic [31:0] i_wr_dcache_data,
  output logic [31:0] o_rd_data,
  output logic        o_busy,
  output logic        o_rd_req,
  output logic        o_rd_type,
  output logic [31:0] o_rd_addr,
  input  logic        i_rd_rdy,
  input  logic        i_ret_valid,
  input  logic        i_ret_last,
  input  logic [31:0] i_ret_data,
  output logic        o_wr_req,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_strb,
  input  logic        i_wr_rdy
);

  localparam int unsigned IDX_W   = $clog2(SET_NUM);
  localparam int unsigned WRD_W   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_LSB = WRD_W + 2;

  dcache_state_e      r_state, w_next;
  logic [4:0]         r_op;
  logic [IDX_W-1:0]   r_set;
  logic [WRD_W-1:0]   r_word;
  logic [31:0]        r_pa;
  logic [31:0]        r_wdata;
  logic               r_cached;
  byte_type_t         r_btype;
  logic [WRD_W-1:0]   r_beat;
  logic [31:0]        r_resp;
  logic [SET_NUM-1:0] r_valid;
  logic [19:0]        r_tag [SET_NUM];

  logic               w_op_valid, w_accept, w_hit, w_is_store, w_unused;
  logic               w_fill_beat, w_ram_we;
  logic [31:0]        w_ram_rdata;
  logic [WRD_W-1:0]   w_ram_wword;
  logic [3:0]         w_ram_wstrb;
  logic [31:0]        w_ram_wdata;

  assign w_unused   = ^i_dcache_idx[1:0];
  assign w_op_valid = (i_dcache_op != DC_NOP);
  assign w_accept   = !o_busy && w_op_valid;
  assign w_is_store = (r_op == DC_W);
  assign w_hit      = r_valid[r_set] && (r_tag[r_set] == r_pa[31:12]) && r_cached;

  // Store outputs come straight from the registered request, so they are stable while wr_req.
  assign o_wr_addr = {r_pa[31:2], 2'b00};
  assign o_wr_data = r_wdata << {r_pa[1:0], 3'b000};
  assign o_wr_strb = byte_strb(r_btype, r_pa[1:0]);

  always_comb begin
    w_next    = r_state;
    o_busy    = 1'b1;
    o_rd_req  = 1'b0;
    o_rd_type = RD_TYPE_WORD;
    o_rd_addr = r_pa;
    o_wr_req  = 1'b0;
    o_rd_data = r_resp;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (w_op_valid) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (w_is_store) begin
          w_next = WRITE;
        end else if (w_hit) begin
          // Load hit completes here and may overlap the next request's lookup.
          o_busy    = 1'b0;
          o_rd_data = w_ram_rdata;
          w_next    = w_op_valid ? LOOKUP : IDLE;
        end else begin
          w_next = r_cached ? MISS : UC_RD;
        end
      end
      MISS: begin
        o_rd_req  = 1'b1;
        o_rd_type = RD_TYPE_LINE;
        o_rd_addr = {r_pa[31:IDX_LSB], {IDX_LSB{1'b0}}};
        if (i_rd_rdy) w_next = REFILL;
      end
      REFILL:  if (i_ret_valid && i_ret_last) w_next = RESP;
      UC_RD: begin
        o_rd_req = 1'b1;
        if (i_rd_rdy) w_next = UC_WAIT;
      end
      UC_WAIT: if (i_ret_valid) w_next = RESP;
      WRITE: begin
        o_wr_req = 1'b1;
        if (i_wr_rdy) w_next = IDLE;
      end
      RESP: begin
        o_busy = 1'b0;
        w_next = w_op_valid ? LOOKUP : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Data RAM is written by refill beats and by cached store hits (during lookup).
  assign w_fill_beat = (r_state == REFILL) && i_ret_valid;
  assign w_ram_we    = w_fill_beat || ((r_state == LOOKUP) && w_is_store && w_hit);
  assign w_ram_wword = w_fill_beat ? r_beat : r_word;
  assign w_ram_wstrb = w_fill_beat ? 4'b1111 : o_wr_strb;
  assign w_ram_wdata = w_fill_beat ? i_ret_data : o_wr_data;

  dcache_data_ram #(
    .SET_NUM    (SET_NUM),
    .LINE_WORDS (LINE_WORDS)
  ) u_data_ram (
    .clk       (clk),
    .i_rd_en   (w_accept),
    .i_rd_set  (i_dcache_idx[IDX_LSB +: IDX_W]),
    .i_rd_word (i_dcache_idx[2 +: WRD_W]),
    .o_rd_data (w_ram_rdata),
    .i_wr_en   (w_ram_we),
    .i_wr_set  (r_set),
    .i_wr_word (w_ram_wword),
    .i_wr_strb (w_ram_wstrb),
    .i_wr_data (w_ram_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= DC_NOP;
      r_set    <= '0;
      r_word   <= '0;
      r_pa     <= '0;
      r_wdata  <= '0;
      r_cached <= 1'b0;
      r_btype  <= WORD;
      r_beat   <= '0;
      r_resp   <= '0;
      r_valid  <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= i_dcache_op;
        r_set    <= i_dcache_idx[IDX_LSB +: IDX_W];
        r_word   <= i_dcache_idx[2 +: WRD_W];
        r_pa     <= i_dcache_pa;
        r_wdata  <= i_wr_dcache_data;
        r_cached <= i_dcache_is_cached;
        r_btype  <= i_dcache_byte_type;
      end
      if (r_state == MISS) r_beat <= '0;
      if (w_fill_beat) begin
        r_beat <= r_beat + 1'b1;
        if (r_beat == r_word) r_resp <= i_ret_data;
        if (i_ret_last) r_valid[r_set] <= 1'b1;
      end
      if ((r_state == UC_WAIT) && i_ret_valid) r_resp <= i_ret_data;
    end
  end

  // Tags need no reset: a tag is only consulted together with its valid bit.
  always_ff @(posedge clk) begin
    if (w_fill_beat && i_ret_last) r_tag[r_set] <= r_pa[31:12];
  end

endmodule
